// File: rtl/logos_pkg.sv
// Shared definitions for the command dispatch queue: opcodes, target codes,
// host command field positions and dispatcher state encoding.
package logos_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    TGT_C0   = 2'b00,
    TGT_C1   = 2'b01,
    TGT_ANY  = 2'b10,
    TGT_BOTH = 2'b11
  } target_e;

  localparam int OPC_HI  = 63;
  localparam int OPC_LO  = 56;
  localparam int SLOT_HI = 55;
  localparam int SLOT_LO = 52;
  localparam int TGT_HI  = 51;
  localparam int TGT_LO  = 50;
  localparam int RSVD_HI = 49;
  localparam int RSVD_LO = 48;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } disp_state_e;

endpackage

// File: rtl/cmd_sync_fifo.sv
// Single-clock FIFO with registered occupancy count. The head word is
// presented combinationally on rdata whenever the FIFO is not empty.
module cmd_sync_fifo #(
  parameter int DEPTH     = 8,
  parameter int DEPTH_LOG = 3,
  parameter int W         = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [W-1:0]         wdata,
  input  logic                 pop,
  output logic [W-1:0]         rdata,
  output logic [DEPTH_LOG:0]   count,
  output logic                 full,
  output logic                 empty
);

  logic [W-1:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0]   wr_ptr;
  logic [DEPTH_LOG-1:0]   rd_ptr;
  logic                   push_ok;
  logic                   pop_ok;

  assign full    = (count == (DEPTH_LOG+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are DEPTH_LOG bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_dispatch_queue.sv
// Buffers host command words and issues them in order to two NTT engines.
// Handshake: host words transfer on host_valid && host_ready; engines take a command on the cmd_valid_N pulse.
module cmd_dispatch_queue
  import logos_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DEPTH_LOG = 3,
  parameter int ADDR_W    = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_valid,
  input  logic [63:0]          host_cmd,
  output logic                 host_ready,
  output logic                 cmd_valid_0,
  output logic                 cmd_valid_1,
  output logic [7:0]           cmd_opcode,
  output logic [3:0]           cmd_slot,
  output logic [ADDR_W-1:0]    cmd_dma_addr,
  input  logic                 engine_ready_0,
  input  logic                 engine_ready_1,
  output logic [DEPTH_LOG:0]   fifo_count,
  output logic                 halted,
  output logic [1:0]           dbg_state
);

  disp_state_e          state_q, state_d;
  logic                 rr_q, rr_d;
  logic                 blackout_0, blackout_1;
  logic                 issue_0, issue_1;
  logic                 pop;
  logic                 push;
  logic                 fifo_full, fifo_empty;
  logic [63:0]          head;
  logic [7:0]           head_op;
  target_e              head_tgt;
  logic                 elig_0, elig_1;
  logic                 unused_rsvd;

  cmd_sync_fifo #(
    .DEPTH     (DEPTH),
    .DEPTH_LOG (DEPTH_LOG),
    .W         (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (host_cmd),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_op     = head[OPC_HI:OPC_LO];
  assign head_tgt    = target_e'(head[TGT_HI:TGT_LO]);
  assign unused_rsvd = ^head[RSVD_HI:RSVD_LO];

  // An engine drops ready only after it sees valid, so ready is ignored in the issue cycle.
  assign elig_0 = engine_ready_0 && !blackout_0;
  assign elig_1 = engine_ready_1 && !blackout_1;

  assign host_ready = (state_q == ST_RUN) && !fifo_full;
  assign push       = host_valid && host_ready;
  assign halted     = (state_q == ST_HALTED);
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    issue_0 = 1'b0;
    issue_1 = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!fifo_empty) begin
          if (head_op == OP_NOP) begin
            pop = 1'b1;
          end else if (head_op == OP_HALT) begin
            pop     = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            case (head_tgt)
              TGT_C0: issue_0 = elig_0;
              TGT_C1: issue_1 = elig_1;
              TGT_ANY: begin
                if (elig_0 && elig_1) begin
                  issue_0 = !rr_q;
                  issue_1 = rr_q;
                  rr_d    = !rr_q;
                end else begin
                  issue_0 = elig_0;
                  issue_1 = elig_1;
                end
              end
              TGT_BOTH: begin
                issue_0 = elig_0 && elig_1;
                issue_1 = elig_0 && elig_1;
              end
            endcase
            pop = issue_0 || issue_1;
          end
        end
      end
      ST_DRAIN: begin
        if (engine_ready_0 && engine_ready_1 && !blackout_0 && !blackout_1) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      rr_q         <= 1'b0;
      blackout_0   <= 1'b0;
      blackout_1   <= 1'b0;
      cmd_valid_0  <= 1'b0;
      cmd_valid_1  <= 1'b0;
      cmd_opcode   <= '0;
      cmd_slot     <= '0;
      cmd_dma_addr <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      blackout_0  <= issue_0;
      blackout_1  <= issue_1;
      cmd_valid_0 <= issue_0;
      cmd_valid_1 <= issue_1;
      if (issue_0 || issue_1) begin
        cmd_opcode   <= head_op;
        cmd_slot     <= head[SLOT_HI:SLOT_LO];
        cmd_dma_addr <= head[ADDR_W-1:0];
      end
    end
  end

endmodule
